reg_dump: RTL and testbench
===========================

# reg_dump

Debug readback engine for the picoMIPS register file: the reading counterpart of the register write path. On a `start` pulse it walks register addresses 0..NREGS-1 through the register file's synchronous read port, captures each value, and presents it with its address on a valid/ready output stream. The output stream feeds the board display or serial logic. The engine sits beside the datapath and only uses the read port while `busy` is high.

## Interface
- WIDTH, 8, data width of one register.
- NREGS, 8, number of registers dumped; 1 <= NREGS <= 2**ADDR_W.
- ADDR_W, 3, register address width.

- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request a dump; sampled only in IDLE.
- rd_en  out  1  read-port enable to register file.
- rd_addr  out  ADDR_W  read-port address.
- rd_data  in  WIDTH  register file read data, valid the cycle after rd_en.
- out_data  out  WIDTH  captured register value.
- out_addr  out  ADDR_W  address of out_data.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, READ, CAPTURE, HOLD.
- IDLE: rd_en=0, out_valid=0, busy=0. If start=1 at edge: addr<=0, go READ.
- READ: rd_en=1, rd_addr=addr (combinational from state). Next edge -> CAPTURE.
- CAPTURE: rd_en=0; at edge out_data<=rd_data, out_addr<=addr, go HOLD.
- HOLD: out_valid=1; out_data/out_addr held stable while out_ready=0.
  - Edge with out_ready=1 and addr!=NREGS-1: addr<=addr+1, go READ.
  - Edge with out_ready=1 and addr==NREGS-1: addr<=0, done<=1 for one cycle, go IDLE.
- Address counter is ADDR_W bits and never passes NREGS-1; wrap to 0 only through the end-of-dump path.
- start while busy: ignored, no restart, no queuing.
- start high in the same cycle done is high, with the state already IDLE: a new dump begins; done and the new READ entry do not conflict.
- rd_data is ignored outside CAPTURE.
- The block never drives the write port; the register file write enable is outside this block.

## Timing
- Reset values: rd_en=0, rd_addr=0, out_data=0, out_addr=0, out_valid=0, busy=0, done=0, state=IDLE, addr=0.
- Reset asserted mid-dump: outputs return to reset values asynchronously; the dump is abandoned and done is not pulsed.
- start at edge E0: READ during cycle E0..E1 (rd_en=1). CAPTURE during E1..E2. out_valid=1 from E2.
- The first word is visible 2 cycles after start is sampled.
- A transfer occurs at any edge with out_valid=1 and out_ready=1. out_ready already high when out_valid rises gives a transfer at the first HOLD edge.
- Minimum 3 cycles per word with out_ready tied high. A full dump takes 3*NREGS cycles from start to IDLE. done is high in the cycle after the last transfer.
- out_valid is never deasserted without a transfer, except by reset.

## Test plan
- Register file preloaded with reg[i]=8'h10+i, NREGS=8, out_ready tied 1, start pulse -> 8 words 0x10..0x17 with out_addr 0..7; each out_valid 3 cycles apart; done pulses exactly once, 24 cycles after start; busy low afterwards.
- Backpressure: out_ready=0 for 5 cycles on word 3 -> out_data=0x13 and out_addr=3 stable throughout; rd_en stays 0; the next READ starts only after the accepting edge.
- start re-pulsed during words 2 and 5 -> ignored; exactly 8 words and one done pulse.
- Reset asserted while in HOLD on word 4 -> out_valid, busy and rd_en drop immediately; no done pulse; the next start dumps from address 0.
- NREGS=1 -> one word from address 0, done after 3 cycles. Back-to-back start in the cycle after done -> a second complete dump with identical data.
- Register file changed between dumps (reg[2]=0xAA) -> the second dump reports 0xAA at out_addr=2, confirming data is taken from rd_data during CAPTURE.

Source files
------------

// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump
//  Purpose  : Walks the register file read port over addresses 0..NREGS-1 and
//             streams each captured value with its address (valid/ready).
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NREGS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [WIDTH-1:0]  r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_capture;
    logic              w_rd_en;
    logic              w_out_valid;
    logic              w_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        w_rd_en     = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_rd_en     = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    // Counter only wraps through the end-of-dump path.
                    if (r_addr == c_LAST) begin
                        w_addr_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = S_READ;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_done     <= 1'b0;
            r_out_data <= '0;
            r_out_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_done  <= w_done_nxt;
            if (w_capture) begin
                r_out_data <= rd_data;
                r_out_addr <= r_addr;
            end
        end
    end

    assign rd_en     = w_rd_en;
    assign rd_addr   = r_addr;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump
//  Purpose  : Directed self-checking bench for reg_dump (NREGS=8 and NREGS=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_dump;

    logic       clk;
    logic       reset;
    logic       start;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic [2:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic       start1;
    logic       rd_en1;
    logic [2:0] rd_addr1;
    logic [7:0] rd_data1;
    logic [7:0] out_data1;
    logic [2:0] out_addr1;
    logic       out_valid1;
    logic       out_ready1;
    logic       busy1;
    logic       done1;

    logic [7:0] regfile [8];
    logic [7:0] rf1;

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_data [16];
    logic [2:0] cap_addr [16];
    int         cap_cyc  [16];
    int         nwords;
    int         done_cnt;
    int         done_cyc;
    int         bad_hold;
    int         timed_out;

    reg_dump #(.WIDTH(8), .NREGS(8), .ADDR_W(3)) u_dut (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    reg_dump #(.WIDTH(8), .NREGS(1), .ADDR_W(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .out_data(out_data1), .out_addr(out_addr1),
        .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read port; junk value when not enabled so a mistimed capture shows.
    always @(posedge clk) begin
        rd_data  <= rd_en  ? regfile[rd_addr] : 8'hEE;
        rd_data1 <= rd_en1 ? rf1 : 8'hEE;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one dump on the NREGS=8 instance (start must already be high).
    task automatic collect(input int stall_word, input int stall_len,
                           input logic [7:0] restart_mask, input int budget);
        int   n;
        int   stall;
        logic pv;
        nwords = 0; done_cnt = 0; done_cyc = -1; bad_hold = 0; timed_out = 0;
        n = 0; stall = 0; pv = 1'b0;
        tick();
        while (n < budget && !(done_cnt > 0 && n >= done_cyc + 4)) begin
            start = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = n;
            end
            if (out_valid && !pv) begin
                if (nwords < 16) begin
                    cap_data[nwords] = out_data;
                    cap_addr[nwords] = out_addr;
                    cap_cyc[nwords]  = n;
                end
                if (nwords == stall_word) begin
                    stall     = stall_len;
                    out_ready = 1'b0;
                end
                if (nwords < 8 && restart_mask[nwords]) start = 1'b1;
                nwords++;
            end else if (stall > 0) begin
                if (out_data !== cap_data[nwords-1] || out_addr !== cap_addr[nwords-1] ||
                    rd_en !== 1'b0 || out_valid !== 1'b1) bad_hold++;
                stall--;
                if (stall == 0) out_ready = 1'b1;
            end
            pv = out_valid;
            tick();
            n++;
        end
        timed_out = (done_cnt == 0) ? 1 : 0;
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; start1 = 1'b0; out_ready1 = 1'b1;
        tick(); tick();
        checks++; if (rd_en !== 1'b0)     begin errors++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
        checks++; if (rd_addr !== 3'd0)   begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_addr !== 3'd0)  begin errors++; $display("FAIL reset_out_addr got=%0d exp=0", out_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_dump();
        out_ready = 1'b1; start = 1'b1;
        collect(-1, 0, 8'h00, 60);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL full_timeout got=%0d exp=0", timed_out); end
        checks++; if (nwords !== 8) begin errors++; $display("FAIL full_nwords got=%0d exp=8", nwords); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (cap_data[k] !== 8'h10 + 8'(k)) begin errors++; $display("FAIL full_data[%0d] got=%h exp=%h", k, cap_data[k], 8'h10 + 8'(k)); end
            checks++; if (cap_addr[k] !== 3'(k)) begin errors++; $display("FAIL full_addr[%0d] got=%0d exp=%0d", k, cap_addr[k], k); end
            checks++; if (cap_cyc[k] !== 2 + 3*k) begin errors++; $display("FAIL full_cycle[%0d] got=%0d exp=%0d", k, cap_cyc[k], 2 + 3*k); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc !== 24) begin errors++; $display("FAIL full_done_cycle got=%0d exp=24", done_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; start = 1'b1;
        collect(3, 5, 8'h00, 80);
        checks++; if (nwords !== 8) begin errors++; $display("FAIL bp_nwords got=%0d exp=8", nwords); end
        checks++; if (cap_data[3] !== 8'h13) begin errors++; $display("FAIL bp_data3 got=%h exp=13", cap_data[3]); end
        checks++; if (cap_addr[3] !== 3'd3) begin errors++; $display("FAIL bp_addr3 got=%0d exp=3", cap_addr[3]); end
        checks++; if (bad_hold !== 0) begin errors++; $display("FAIL bp_hold_unstable got=%0d exp=0", bad_hold); end
        checks++; if (cap_cyc[4] !== 19) begin errors++; $display("FAIL bp_next_word_cycle got=%0d exp=19", cap_cyc[4]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc !== 29) begin errors++; $display("FAIL bp_done_cycle got=%0d exp=29", done_cyc); end
    endtask

    task automatic test_start_ignored();
        out_ready = 1'b1; start = 1'b1;
        collect(-1, 0, 8'b0010_0100, 60);
        checks++; if (nwords !== 8) begin errors++; $display("FAIL restart_nwords got=%0d exp=8", nwords); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc !== 24) begin errors++; $display("FAIL restart_done_cycle got=%0d exp=24", done_cyc); end
        checks++; if (cap_addr[7] !== 3'd7 || cap_data[7] !== 8'h17) begin errors++; $display("FAIL restart_last got=%0d/%h exp=7/17", cap_addr[7], cap_data[7]); end
    endtask

    task automatic test_reset_mid_dump();
        int found;
        int dn;
        found = 0; dn = 0;
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (out_valid && out_addr == 3'd4) found = 1;
            else tick();
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL rst_reach_word4 got=%0d exp=1", found); end
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_async_rd_en got=%b exp=0", rd_en); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_async_data got=%h exp=00", out_data); end
        tick(); tick();
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", dn); end
        start = 1'b1;
        collect(-1, 0, 8'h00, 60);
        checks++; if (nwords !== 8) begin errors++; $display("FAIL rst_redump_nwords got=%0d exp=8", nwords); end
        checks++; if (cap_addr[0] !== 3'd0 || cap_data[0] !== 8'h10) begin errors++; $display("FAIL rst_redump_first got=%0d/%h exp=0/10", cap_addr[0], cap_data[0]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rst_redump_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_nregs1_back_to_back();
        out_ready1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++; if (rd_en1 !== 1'b1 || rd_addr1 !== 3'd0) begin errors++; $display("FAIL n1_read got=%b/%0d exp=1/0", rd_en1, rd_addr1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL n1_busy got=%b exp=1", busy1); end
        tick();
        checks++; if (out_valid1 !== 1'b0 || rd_en1 !== 1'b0) begin errors++; $display("FAIL n1_capture got=%b/%b exp=0/0", out_valid1, rd_en1); end
        tick();
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 8'h5A || out_addr1 !== 3'd0) begin errors++; $display("FAIL n1_word got=%b/%h/%0d exp=1/5a/0", out_valid1, out_data1, out_addr1); end
        tick();
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL n1_done got=%b/%b exp=1/0", done1, busy1); end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++; if (rd_en1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL b2b_restart got=%b/%b exp=1/0", rd_en1, done1); end
        tick(); tick();
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 8'h5A) begin errors++; $display("FAIL b2b_word got=%b/%h exp=1/5a", out_valid1, out_data1); end
        tick();
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done1); end
        tick();
    endtask

    task automatic test_data_change();
        regfile[2] = 8'hAA;
        out_ready = 1'b1; start = 1'b1;
        collect(-1, 0, 8'h00, 60);
        checks++; if (cap_data[2] !== 8'hAA || cap_addr[2] !== 3'd2) begin errors++; $display("FAIL chg_word2 got=%h/%0d exp=aa/2", cap_data[2], cap_addr[2]); end
        checks++; if (cap_data[1] !== 8'h11 || cap_data[3] !== 8'h13) begin errors++; $display("FAIL chg_neighbours got=%h/%h exp=11/13", cap_data[1], cap_data[3]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL chg_done got=%0d exp=1", done_cnt); end
        regfile[2] = 8'h12;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regfile[i] = 8'h10 + 8'(i);
        rf1 = 8'h5A;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_dump();
        test_nregs1_back_to_back();
        test_data_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
